// File: rtl/csr_ctrl.sv
// CSR-file initiator: sequences CSRRW/CSRRS/CSRRC, ECALL, EBREAK and MRET as read-modify-write.
// Optional build macro CSR_CTRL_ILLEGAL_EN adds an illegal-address / read-only-write trap.
module csr_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter logic [3:0]  ECALL_CAUSE  = 4'd11,
  parameter logic [3:0]  EBREAK_CAUSE = 4'd3
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_src,
  input  logic            i_rs1_zero,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_pc,
  output logic [11:0]     o_csr_r,
  input  logic [XLEN-1:0] i_csr_rdata,
  output logic [11:0]     o_csr_w,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic [1:0]      o_csr_t,
  output logic            o_exception,
  output logic [3:0]      o_mcause,
  output logic            o_mret,
  output logic [XLEN-1:0] o_csr_pc,
  output logic            o_csr_valid,
  input  logic [XLEN-1:0] i_csr_upc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_rd_wdata,
  output logic            o_rd_wen,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_npc
);

  localparam logic [2:0] OpCsrrw  = 3'b000;
  localparam logic [2:0] OpCsrrs  = 3'b001;
  localparam logic [2:0] OpCsrrc  = 3'b010;
  localparam logic [2:0] OpEcall  = 3'b011;
  localparam logic [2:0] OpEbreak = 3'b100;
  localparam logic [2:0] OpMret   = 3'b101;

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  typedef enum logic [1:0] {StIdle, StRead, StCommit, StResp} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q, pc_q, old_q, wdata_q, upc_q;
  logic            rs1_zero_q;
  logic [4:0]      rd_q;
  logic            illegal_q;

  logic            is_csr, csr_write, trap, illegal_d;
  logic [XLEN-1:0] wdata_d;

  assign is_csr    = (op_q == OpCsrrw) || (op_q == OpCsrrs) || (op_q == OpCsrrc);
  // Set/clear with a zero operand is a pure read and must not touch the CSR.
  assign csr_write = is_csr && ((op_q == OpCsrrw) || !rs1_zero_q);
  assign trap      = illegal_q || (op_q == OpEcall) || (op_q == OpEbreak);

  always_comb begin
    wdata_d = src_q;
    case (op_q)
      OpCsrrs: wdata_d = i_csr_rdata | src_q;
      OpCsrrc: wdata_d = i_csr_rdata & ~src_q;
      default: wdata_d = src_q;
    endcase
  end

`ifdef CSR_CTRL_ILLEGAL_EN
  logic addr_known;
  always_comb begin
    case (addr_q)
      12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12: addr_known = 1'b1;
      default:                                              addr_known = 1'b0;
    endcase
  end
  // addr[11:10] == 2'b11 marks a read-only CSR.
  assign illegal_d = is_csr && (!addr_known || (csr_write && (addr_q[11:10] == 2'b11)));
`else
  assign illegal_d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_valid) state_d = StRead;
      StRead:   state_d = StCommit;
      StCommit: state_d = StResp;
      StResp:   if (i_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      rs1_zero_q <= 1'b0;
      rd_q       <= '0;
      pc_q       <= '0;
      old_q      <= '0;
      wdata_q    <= '0;
      upc_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && i_valid) begin
        op_q       <= i_op;
        addr_q     <= i_csr_addr;
        src_q      <= i_src;
        rs1_zero_q <= i_rs1_zero;
        rd_q       <= i_rd;
        pc_q       <= i_pc;
      end
      if (state_q == StRead) begin
        old_q     <= i_csr_rdata;
        wdata_q   <= wdata_d;
        illegal_q <= illegal_d;
      end
      if (state_q == StCommit) upc_q <= i_csr_upc;
    end
  end

  always_comb begin
    o_ready     = 1'b0;
    o_csr_r     = '0;
    o_csr_w     = '0;
    o_csr_wdata = '0;
    o_csr_t     = 2'b00;
    o_exception = 1'b0;
    o_mcause    = '0;
    o_mret      = 1'b0;
    o_csr_pc    = '0;
    o_csr_valid = 1'b0;
    o_valid     = 1'b0;
    o_rd        = '0;
    o_rd_wdata  = '0;
    o_rd_wen    = 1'b0;
    o_redirect  = 1'b0;
    o_npc       = '0;
    unique case (state_q)
      StIdle: o_ready = 1'b1;
      StRead: o_csr_r = addr_q;
      StCommit: begin
        o_csr_valid = 1'b1;
        if (trap) begin
          o_csr_t     = 2'b11;
          o_exception = 1'b1;
          o_mcause    = illegal_q ? 4'd2 : ((op_q == OpEcall) ? ECALL_CAUSE : EBREAK_CAUSE);
          o_csr_pc    = pc_q;
        end else if (op_q == OpMret) begin
          o_mret = 1'b1;
        end else if (csr_write) begin
          o_csr_t     = 2'b01;
          o_csr_w     = addr_q;
          o_csr_wdata = wdata_q;
        end
      end
      StResp: begin
        o_valid    = 1'b1;
        o_rd       = rd_q;
        o_rd_wdata = old_q;
        if (trap || (op_q == OpMret)) begin
          o_redirect = 1'b1;
          o_npc      = upc_q;
        end else begin
          o_rd_wen = is_csr && (rd_q != 5'd0);
          o_npc    = pc_q + PcStep;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Randomised bench for csr_ctrl: transaction-level reference model, per-cycle compare,
// plus directed literal checks. Honours CSR_CTRL_ILLEGAL_EN when defined.
module tb_csr_ctrl;
  logic        i_clock, i_reset, i_valid, o_ready;
  logic [2:0]  i_op;
  logic [11:0] i_csr_addr, o_csr_r, o_csr_w;
  logic [31:0] i_src, i_pc, i_csr_rdata, o_csr_wdata, o_csr_pc, i_csr_upc, o_rd_wdata, o_npc;
  logic        i_rs1_zero, o_exception, o_mret, o_csr_valid, o_valid, i_ready, o_rd_wen, o_redirect;
  logic [4:0]  i_rd, o_rd;
  logic [1:0]  o_csr_t;
  logic [3:0]  o_mcause;

  csr_ctrl dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_csr_addr(i_csr_addr), .i_src(i_src), .i_rs1_zero(i_rs1_zero), .i_rd(i_rd), .i_pc(i_pc),
    .o_csr_r(o_csr_r), .i_csr_rdata(i_csr_rdata), .o_csr_w(o_csr_w), .o_csr_wdata(o_csr_wdata),
    .o_csr_t(o_csr_t), .o_exception(o_exception), .o_mcause(o_mcause), .o_mret(o_mret),
    .o_csr_pc(o_csr_pc), .o_csr_valid(o_csr_valid), .i_csr_upc(i_csr_upc), .o_valid(o_valid),
    .i_ready(i_ready), .o_rd(o_rd), .o_rd_wdata(o_rd_wdata), .o_rd_wen(o_rd_wen),
    .o_redirect(o_redirect), .o_npc(o_npc)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Reference model: CSR file contents plus the one in-flight request.
  logic [31:0] csrs [4096];
  int          m_phase = 0;  // 0 waiting, 1 read, 2 commit, 3 response
  logic [2:0]  m_op;
  logic [11:0] m_addr;
  logic [31:0] m_src, m_pc, m_old, m_upc;
  logic        m_rz;
  logic [4:0]  m_rd;
  logic [31:0] junk_r, junk_u, upc_val;
  logic        preset_en;
  logic [11:0] preset_addr;
  logic [31:0] preset_val;
  bit          started = 1'b0;

  int n_cmp = 0, n_bad = 0;
  int csrv_count = 0, wr_count = 0, mret_count = 0;
  logic [31:0] last_wdata, last_csr_pc;
  logic [3:0]  last_mcause;
  logic [1:0]  last_t;

  logic        lit_go;
  string       lit_nm;
  logic [31:0] lit_act, lit_exp;

  logic [11:0] pool [8] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h123, 12'hC00};

  function automatic logic f_ill(input logic [2:0] op, input logic [11:0] a, input logic rz);
`ifdef CSR_CTRL_ILLEGAL_EN
    logic known, wr;
    if (op > 3'd2) return 1'b0;
    known = (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342) ||
            (a == 12'hF11) || (a == 12'hF12);
    wr = (op == 3'd0) || !rz;
    return !known || (wr && (a >= 12'hC00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] f_t(input logic [2:0] op, input logic rz, input logic ill);
    if (ill) return 2'b11;
    if (op <= 3'd2) return ((op == 3'd0) || !rz) ? 2'b01 : 2'b00;
    if ((op == 3'd3) || (op == 3'd4)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] old,
                                          input logic [31:0] src);
    case (op)
      3'd0:    return src;
      3'd1:    return old | src;
      3'd2:    return old & ~src;
      default: return 32'h0;
    endcase
  endfunction

  assign i_csr_rdata = (m_phase == 1) ? csrs[o_csr_r] : junk_r;
  assign i_csr_upc   = (m_phase == 2) ? upc_val : junk_u;

  always @(posedge i_clock) begin
    junk_r  <= $urandom;
    junk_u  <= $urandom;
    started <= 1'b1;
    if (!started) for (int i = 0; i < 4096; i++) csrs[i] <= $urandom;
    if (preset_en) csrs[preset_addr] <= preset_val;
    if (!i_reset) m_phase <= 0;
    else begin
      case (m_phase)
        0: if (i_valid) begin
          m_op <= i_op; m_addr <= i_csr_addr; m_src <= i_src; m_rz <= i_rs1_zero;
          m_rd <= i_rd; m_pc <= i_pc; m_phase <= 1;
        end
        1: begin m_old <= csrs[m_addr]; m_phase <= 2; end
        2: begin
          m_upc <= upc_val;
          if (f_t(m_op, m_rz, f_ill(m_op, m_addr, m_rz)) == 2'b01)
            csrs[m_addr] <= f_wdata(m_op, m_old, m_src);
          m_phase <= 3;
        end
        default: if (i_ready) m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  logic       ex_ill, ex_csr, ex_exc, ex_trap;
  logic [1:0] ex_t;
  always @(negedge i_clock) if (started) begin
    ex_ill  = f_ill(m_op, m_addr, m_rz);
    ex_csr  = (m_op <= 3'd2);
    ex_exc  = ex_ill || (m_op == 3'd3) || (m_op == 3'd4);
    ex_trap = ex_exc || (m_op == 3'd5);
    ex_t    = f_t(m_op, m_rz, ex_ill);
    if (lit_go) chk(lit_nm, lit_act, lit_exp);
    case (m_phase)
      0: begin
        chk("idle_ready", o_ready, 1); chk("idle_valid", o_valid, 0);
        chk("idle_strobes", {o_csr_valid, o_exception, o_mret}, 0);
      end
      1: begin
        chk("read_ready", o_ready, 0); chk("read_valid", o_valid, 0);
        chk("read_addr", o_csr_r, m_addr);
        chk("read_strobes", {o_csr_valid, o_exception, o_mret}, 0);
      end
      2: begin
        chk("commit_ready", o_ready, 0); chk("commit_valid", o_valid, 0);
        chk("commit_csr_valid", o_csr_valid, 1); chk("commit_t", o_csr_t, ex_t);
        chk("commit_exc", o_exception, ex_exc);
        chk("commit_mret", o_mret, (m_op == 3'd5) && !ex_ill);
        if (ex_t == 2'b01) begin
          chk("commit_waddr", o_csr_w, m_addr);
          chk("commit_wdata", o_csr_wdata, f_wdata(m_op, m_old, m_src));
        end
        if (ex_exc) begin
          chk("commit_mcause", o_mcause, ex_ill ? 4'd2 : ((m_op == 3'd3) ? 4'd11 : 4'd3));
          chk("commit_pc", o_csr_pc, m_pc);
        end
      end
      default: begin
        chk("resp_valid", o_valid, 1); chk("resp_ready", o_ready, 0);
        chk("resp_strobes", {o_csr_valid, o_exception, o_mret}, 0);
        chk("resp_wen", o_rd_wen, !ex_trap && ex_csr && (m_rd != 5'd0));
        chk("resp_redirect", o_redirect, ex_trap);
        chk("resp_npc", o_npc, ex_trap ? m_upc : m_pc + 32'd4);
        if (ex_csr && !ex_ill) begin
          chk("resp_rd", o_rd, m_rd); chk("resp_rd_wdata", o_rd_wdata, m_old);
        end
      end
    endcase
    if (o_csr_valid) begin
      csrv_count++;
      last_t = o_csr_t; last_wdata = o_csr_wdata; last_mcause = o_mcause; last_csr_pc = o_csr_pc;
      if (o_csr_t == 2'b01) wr_count++;
      if (o_mret) mret_count++;
    end
  end

  // Driver-side helpers; literal checks are handed to the compare process.
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_nm = nm; lit_act = act; lit_exp = exp; lit_go = 1'b1;
    @(posedge i_clock); #1;
    lit_go = 1'b0;
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] v);
    preset_addr = a; preset_val = v; preset_en = 1'b1;
    @(posedge i_clock); #1;
    preset_en = 1'b0;
  endtask

  logic [31:0] r_rd_wdata, r_npc;
  logic        r_wen, r_redirect;
  int          r_lat;

  task automatic run_txn(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src,
                         input logic rz, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] upc, input int hold);
    int n;
    upc_val = upc; i_op = op; i_csr_addr = a; i_src = src; i_rs1_zero = rz; i_rd = rd;
    i_pc = pc; i_valid = 1'b1; i_ready = 1'b0;
    n = 0;
    while (!o_ready && n < 20) begin @(posedge i_clock); #1; n++; end
    @(posedge i_clock); #1;
    // Keep a different request pending; it must be ignored until the response drains.
    i_op = 3'($urandom); i_csr_addr = 12'($urandom); i_src = $urandom; i_pc = $urandom;
    n = 0;
    while (!o_valid && n < 10) begin @(posedge i_clock); #1; n++; end
    r_lat = n; r_rd_wdata = o_rd_wdata; r_npc = o_npc; r_wen = o_rd_wen; r_redirect = o_redirect;
    repeat (hold) begin @(posedge i_clock); #1; end
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    i_ready = 1'b0; i_valid = 1'b0;
    lit("latency", r_lat, 2);
  endtask

  int w0, c0, m0;
  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b0; preset_en = 1'b0; lit_go = 1'b0;
    i_op = '0; i_csr_addr = '0; i_src = '0; i_rs1_zero = 1'b0; i_rd = '0; i_pc = '0;
    upc_val = '0;
    repeat (3) @(posedge i_clock);
    #1 i_reset = 1'b1;
    lit("reset_ready", o_ready, 1);
    lit("reset_valid", o_valid, 0);

    // Reset while in COMMIT.
    i_op = 3'd0; i_csr_addr = 12'h340; i_src = 32'h1234; i_rd = 5'd1; i_pc = 32'h100;
    i_valid = 1'b1;
    @(posedge i_clock); #1 i_valid = 1'b0;
    @(posedge i_clock); #1 i_reset = 1'b0;
    @(posedge i_clock); #1 i_reset = 1'b1;
    c0 = csrv_count;
    lit("rst_mid_valid", o_valid, 0);
    lit("rst_mid_ready", o_ready, 1);
    repeat (3) @(posedge i_clock);
    #1 lit("rst_mid_no_commit", csrv_count, c0);

    preset(12'h305, 32'h0); w0 = wr_count;
    run_txn(3'd0, 12'h305, 32'h80000100, 1'b0, 5'd5, 32'h80000000, 32'h11111111, 0);
    lit("rw_rd_wdata", r_rd_wdata, 32'h0); lit("rw_wen", r_wen, 1);
    lit("rw_npc", r_npc, 32'h80000004); lit("rw_writes", wr_count - w0, 1);
    lit("rw_wdata", last_wdata, 32'h80000100);

    preset(12'h300, 32'h8);
    run_txn(3'd1, 12'h300, 32'h1888, 1'b0, 5'd3, 32'h200, 32'h0, 1);
    lit("rs_wdata", last_wdata, 32'h1888); lit("rs_old", r_rd_wdata, 32'h8);
    preset(12'h300, 32'h8); w0 = wr_count;
    run_txn(3'd1, 12'h300, 32'h1888, 1'b1, 5'd3, 32'h204, 32'h0, 0);
    lit("rs_zero_writes", wr_count - w0, 0); lit("rs_zero_t", last_t, 0);
    lit("rs_zero_old", r_rd_wdata, 32'h8);
    preset(12'h300, 32'h1888);
    run_txn(3'd2, 12'h300, 32'h8, 1'b0, 5'd3, 32'h208, 32'h0, 0);
    lit("rc_wdata", last_wdata, 32'h1880);

    run_txn(3'd3, 12'h000, 32'h0, 1'b0, 5'd0, 32'h80000020, 32'h80000100, 0);
    lit("ecall_cause", last_mcause, 11); lit("ecall_pc", last_csr_pc, 32'h80000020);
    lit("ecall_redirect", r_redirect, 1); lit("ecall_npc", r_npc, 32'h80000100);
    lit("ecall_wen", r_wen, 0);

    m0 = mret_count;
    run_txn(3'd5, 12'h000, 32'h0, 1'b0, 5'd0, 32'h80000040, 32'h80000020, 3);
    lit("mret_strobe", mret_count - m0, 1); lit("mret_t", last_t, 0);
    lit("mret_npc", r_npc, 32'h80000020);

    run_txn(3'd1, 12'h341, 32'h0, 1'b1, 5'd2, 32'hFFFFFFFC, 32'h0, 0);
    lit("npc_wrap", r_npc, 32'h0);

`ifdef CSR_CTRL_ILLEGAL_EN
    preset(12'hF11, 32'h79737978); w0 = wr_count;
    run_txn(3'd0, 12'hF11, 32'h5, 1'b0, 5'd7, 32'h300, 32'h80000100, 0);
    lit("ill_cause", last_mcause, 2); lit("ill_writes", wr_count - w0, 0);
    lit("ill_npc", r_npc, 32'h80000100); lit("ill_wen", r_wen, 0);
    run_txn(3'd1, 12'hF11, 32'h0, 1'b1, 5'd7, 32'h304, 32'h80000100, 0);
    lit("ro_read_old", r_rd_wdata, 32'h79737978); lit("ro_read_wen", r_wen, 1);
`endif

    for (int c = 0; c < 4000; c++) begin
      i_valid    = 1'($urandom_range(0, 1));
      i_op       = 3'($urandom);
      i_csr_addr = pool[$urandom_range(0, 7)];
      i_src      = $urandom;
      i_rs1_zero = ($urandom_range(0, 3) == 0);
      i_rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      i_pc       = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      i_ready    = ($urandom_range(0, 2) != 0);
      upc_val    = $urandom;
      i_reset    = ($urandom_range(0, 199) != 0);
      @(posedge i_clock); #1;
    end
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    repeat (6) @(posedge i_clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_ctrl.md
Name: csr_ctrl

Overview:
- Initiator side of the CSR-file interface: sequences SYSTEM-class instructions (CSRRW/CSRRS/CSRRC, ECALL, EBREAK, MRET) against the CSR register file.
- Sits between the decode/execute stage and the CSR file. Performs a read-modify-write on the CSR port, raises exception or mret strobes, and returns rd writeback data plus a PC redirect to the core over a valid/ready handshake.

Parameters:
- XLEN, 32, data/PC width.
- ECALL_CAUSE, 4'd11, mcause value for ECALL (M-mode).
- EBREAK_CAUSE, 4'd3, mcause value for EBREAK.

Ports:
- i_clock  input  1  sole clock
- i_reset  input  1  synchronous, active-low reset
- i_valid  input  1  request valid
- o_ready  output 1  request accepted when i_valid&&o_ready at rising edge
- i_op  input  3  000 CSRRW, 001 CSRRS, 010 CSRRC, 011 ECALL, 100 EBREAK, 101 MRET; others treated as no-op
- i_csr_addr  input  12  CSR address
- i_src  input  XLEN  operand (rs1 value or zimm, pre-selected by decode)
- i_rs1_zero  input  1  rs1/zimm field is zero
- i_rd  input  5  destination register
- i_pc  input  XLEN  instruction PC
- o_csr_r  output 12  CSR read address
- i_csr_rdata  input  XLEN  CSR read data (combinational from CSR file)
- o_csr_w  output 12  CSR write address
- o_csr_wdata  output XLEN  CSR write data
- o_csr_t  output 2  00 none/mret, 01 write, 11 exception
- o_exception  output 1  exception strobe
- o_mcause  output 4  cause for exception
- o_mret  output 1  mret strobe
- o_csr_pc  output XLEN  PC presented as mepc source
- o_csr_valid  output 1  CSR-file commit enable
- i_csr_upc  input  XLEN  trap/return target from CSR file
- o_valid  output 1  response valid
- i_ready  input  1  response consumed
- o_rd  output 5  writeback register
- o_rd_wdata  output XLEN  old CSR value
- o_rd_wen  output 1  writeback enable
- o_redirect  output 1  next PC is a trap/return target
- o_npc  output XLEN  next PC

Behaviour:
- FSM states: IDLE, READ, COMMIT, RESP. The state and all outputs update only on a rising i_clock.
- Reset (i_reset==0 at edge): state→IDLE from any state, including mid-operation. All latched fields, o_valid, o_csr_valid, o_exception, o_mret, o_rd_wen and o_redirect clear to 0. o_csr_t=00. o_ready=1 once in IDLE.
- IDLE: o_ready=1. On i_valid at the edge, latch op, addr, src, rs1_zero, rd and pc, then go to READ. With i_valid low, stay in IDLE.
- READ: o_csr_r=latched addr. At the edge, capture i_csr_rdata as old, compute wdata, then go to COMMIT.
  - CSRRW: wdata=src.
  - CSRRS: wdata=old|src.
  - CSRRC: wdata=old&~src.
- COMMIT: o_csr_valid=1 for exactly one cycle. Capture i_csr_upc at the edge, then go to RESP.
  - CSR ops: o_csr_t=01, o_csr_w=addr, o_csr_wdata=wdata.
  - CSR write suppression: for CSRRS/CSRRC with rs1_zero=1, o_csr_t=00 (no write). CSRRW always writes.
  - ECALL/EBREAK: o_csr_t=11, o_exception=1, o_mcause=ECALL_CAUSE or EBREAK_CAUSE, o_csr_pc=pc.
  - MRET: o_csr_t=00, o_mret=1.
  - No-op: o_csr_valid=1 with o_csr_t=00.
- RESP: o_valid=1, with outputs held stable until i_ready; on i_valid&&... on o_valid&&i_ready at the edge, go to IDLE.
  - CSR ops: o_rd=rd, o_rd_wdata=old, o_rd_wen=(rd!=0), o_redirect=0, o_npc=pc+4 (mod 2^XLEN, wraps).
  - ECALL/EBREAK/MRET: o_rd_wen=0, o_redirect=1, o_npc=captured upc.
  - No-op: o_rd_wen=0, o_redirect=0, o_npc=pc+4.
- Timing and handshake rules:
  - Latency: accept at edge E0; o_valid high after E2. Earliest next accept is at E4 (RESP→IDLE at E3 with i_ready=1, IDLE accepts at E4).
  - o_ready=0 in READ, COMMIT and RESP. i_valid in those states is ignored; request inputs need not be stable after acceptance.
  - Strobes (o_csr_valid, o_exception, o_mret) are never asserted outside COMMIT.

Optional Feature:
- Macro: CSR_CTRL_ILLEGAL_EN.
- Defined: during READ, flag illegal when either condition holds:
  - addr is not in {0x300, 0x305, 0x341, 0x342, 0xF11, 0xF12} for a CSR op;
  - a write would occur (see write suppression) and addr[11:10]==2'b11 (read-only).
- Illegal op in COMMIT behaves as an exception: o_csr_t=11, o_exception=1, o_mcause=4'd2, o_csr_pc=pc, no CSR write. In RESP it behaves as a trap: o_rd_wen=0, o_redirect=1, o_npc=upc.
- Undefined: no address check; all CSR ops are issued as described, and the CSR file handles unknown/read-only addresses.

Test Plan:
- Reset mid-op: accept CSRRW, assert i_reset=0 while in COMMIT → no o_csr_valid afterwards; o_valid=0; o_ready=1 the cycle after reset releases.
- CSRRW 0x305, src=0x80000100, rd=5, CSR old=0x0 → write strobe 0x305/0x80000100 exactly once; o_rd_wdata=0, o_rd_wen=1, o_npc=pc+4, o_valid after 2 edges.
- CSRRS 0x300, src=0x1888, old=0x00000008 → wdata=0x1888; same with rs1_zero=1 → o_csr_t=00, rd still gets 0x8. CSRRC src=0x8, old=0x1888 → wdata=0x1880.
- ECALL pc=0x80000020, mtvec=0x80000100 → o_exception=1, o_mcause=11, o_csr_pc=0x80000020; o_redirect=1, o_npc=0x80000100, o_rd_wen=0.
- MRET with mepc=0x80000020 → o_mret=1, o_csr_t=00; o_npc=0x80000020. Hold i_ready=0 for 3 cycles → outputs stable; new i_valid ignored.
- With CSR_CTRL_ILLEGAL_EN: CSRRW 0xF11 → o_mcause=2, no write, o_npc=mtvec. CSRRS 0xF11 rs1_zero=1 → legal, rd=0x79737978.
